seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector, the successor to the fixed-pattern 4-bit Mealy detectors in the FSM library. It has a runtime-programmable pattern of 1..MAX_LEN bits and a selectable overlapping/non-overlapping mode. Input bits are qualified by a valid strobe, and a saturating match counter is included. It sits directly on a serial bit stream, and its `match` pulse feeds downstream framing or event logic.

---
 rtl/fsm_lib_pkg.sv | 21 ++
 rtl/sat_counter.sv | 29 ++
 rtl/seq_detect_param.sv | 98 +++++++++
 tb/tb_seq_detect_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_lib_pkg.sv
// ============================================================================
// fsm_lib_pkg : shared state encoding and helpers for the FSM library
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fsm_lib_pkg;

   typedef enum logic [0:0] {
      UNCFG = 1'b0,
      RUN   = 1'b1
   } seq_state_t;

   // True when a requested pattern length is usable: 1..max inclusive.
   function automatic logic min_len_ok(input int unsigned len, input int unsigned max);
      return (len != 0) && (len <= max);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : event counter that holds at all-ones; clear beats increment
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
// seq_detect_param : programmable serial pattern detector (1..MAX_LEN bits)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module seq_detect_param
   import fsm_lib_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               cfg_err,
   input  logic               in_valid,
   input  logic               in,
   output logic               match,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam logic [LEN_W-1:0] c_fill_max = LEN_W'(MAX_LEN);
   localparam logic [MAX_LEN:0] c_one      = (MAX_LEN + 1)'(1);

   seq_state_t         r_state;
   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;

   logic               w_cfg_ok;
   logic               w_consume;
   logic [MAX_LEN-1:0] w_hist_n;
   logic [LEN_W-1:0]   w_fill_n;
   logic [MAX_LEN:0]   w_mask_full;
   logic [MAX_LEN-1:0] w_mask;

   assign w_cfg_ok  = min_len_ok(32'(cfg_len), MAX_LEN);
   // A load in the same cycle as a valid bit wins; that bit is dropped.
   assign w_consume = (r_state == RUN) && in_valid && !cfg_load;

   assign w_hist_n    = {r_hist[MAX_LEN-2:0], in};
   assign w_fill_n    = (r_fill == c_fill_max) ? r_fill : r_fill + LEN_W'(1);
   assign w_mask_full = (c_one << r_len) - c_one;
   assign w_mask      = w_mask_full[MAX_LEN-1:0];

   assign match = w_consume && (w_fill_n >= r_len) &&
                  (((w_hist_n ^ r_pattern) & w_mask) == '0);

   assign armed = (r_state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= UNCFG;
         r_hist    <= '0;
         r_fill    <= '0;
         r_pattern <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= cfg_load && !w_cfg_ok;
         if (cfg_load && w_cfg_ok) begin
            r_state   <= RUN;
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
         end else if (w_consume) begin
            r_hist <= w_hist_n;
            // Emptying the fill count keeps matched bits out of later windows.
            r_fill <= (match && !r_overlap) ? '0 : w_fill_n;
         end
      end
   end

   sat_counter #(
      .W   (CNT_W)
   ) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .inc (match),
      .clr (cnt_clr),
      .cnt (match_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
// tb_seq_detect_param : directed + random bench with a queue-based model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 16;

   logic               clk = 1'b0;
   logic               rst, cfg_load, cfg_overlap, in_valid, in, cnt_clr;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_err, match, armed;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err_s, match_s, armed_s;
   logic [1:0]         match_cnt_s;

   int n_tests = 0;
   int n_fail  = 0;
   logic m_obs;

   always #5 clk = ~clk;

   seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
      .in_valid(in_valid), .in(in), .match(match), .cnt_clr(cnt_clr),
      .match_cnt(match_cnt), .armed(armed)
   );

   seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err_s),
      .in_valid(in_valid), .in(in), .match(match_s), .cnt_clr(cnt_clr),
      .match_cnt(match_cnt_s), .armed(armed_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the window is the list of bits received since the last
   // (re)load or non-overlapping match; a match is the tail equalling the pattern.
   bit               m_armed, m_ovl, m_err;
   bit [MAX_LEN-1:0] m_pat;
   int               m_len;
   bit               m_q[$];
   int               m_c16, m_c2;

   initial begin
      bit e_match, consume, ok, legal;
      bit tmp[$];
      int sz;
      m_armed = 0; m_ovl = 0; m_err = 0; m_pat = '0; m_len = 0;
      m_c16 = 0; m_c2 = 0;
      m_q.delete();
      forever begin
         @(negedge clk);
         e_match = 0;
         consume = m_armed && in_valid && !cfg_load;
         tmp = m_q;
         if (consume) begin
            tmp.push_back(bit'(in));
            if (tmp.size() > MAX_LEN) void'(tmp.pop_front());
            sz = tmp.size();
            if (sz >= m_len) begin
               ok = 1;
               for (int k = 0; k < m_len; k++)
                  if (tmp[sz - m_len + k] != m_pat[m_len - 1 - k]) ok = 0;
               e_match = ok;
            end
         end
         check("match",   match,       e_match);
         check("match_s", match_s,     e_match);
         check("armed",   armed,       m_armed);
         check("cfg_err", cfg_err,     m_err);
         check("cnt16",   match_cnt,   m_c16);
         check("cnt2",    match_cnt_s, m_c2);

         if (rst) begin
            m_armed = 0; m_ovl = 0; m_err = 0; m_pat = '0; m_len = 0;
            m_c16 = 0; m_c2 = 0;
            m_q.delete();
         end else begin
            legal = (cfg_len >= 1) && (int'(cfg_len) <= MAX_LEN);
            m_err = cfg_load && !legal;
            if (cnt_clr) begin
               m_c16 = 0; m_c2 = 0;
            end else if (e_match) begin
               if (m_c16 < (1 << CNT_W) - 1) m_c16++;
               if (m_c2 < 3) m_c2++;
            end
            if (cfg_load && legal) begin
               m_armed = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
               m_ovl = cfg_overlap; m_q.delete();
            end else if (consume) begin
               m_q = tmp;
               if (e_match && !m_ovl) m_q.delete();
            end
         end
      end
   end

   task automatic drive(input logic v, input logic b, input logic ld,
                        input logic clr, input logic r);
      @(posedge clk);
      #1;
      in_valid = v; in = b; cfg_load = ld; cnt_clr = clr; rst = r;
      #2;
      m_obs = match;
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      drive(0, 0, 1, 0, 0);
   endtask

   task automatic send(input logic b);
      drive(1, b, 0, 0, 0);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [7:0] hits;
      logic [7:0] stream;
      logic [1:0] sat_obs [5];
      logic [1:0] sat_exp [5];
      rst = 1; cfg_load = 0; cfg_overlap = 0; in_valid = 0; in = 0; cnt_clr = 0;
      cfg_pattern = '0; cfg_len = '0;
      repeat (3) drive(0, 0, 0, 0, 1);
      idle();
      check("rst_armed", armed, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_err", cfg_err, 0);

      // Overlapping then non-overlapping on 10101010
      stream = 8'b10101010;
      load(8'b1010, 4, 1);
      hits = '0;
      for (int i = 0; i < 8; i++) begin send(stream[7-i]); hits[i] = m_obs; end
      idle();
      check("ovl_hits", hits, 8'b10101000);
      check("ovl_cnt", match_cnt, 3);
      drive(0, 0, 0, 1, 0);
      load(8'b1010, 4, 0);
      hits = '0;
      for (int i = 0; i < 8; i++) begin send(stream[7-i]); hits[i] = m_obs; end
      idle();
      check("novl_hits", hits, 8'b10001000);
      check("novl_cnt", match_cnt, 2);

      // Bubbles between bits
      load(8'b1011, 4, 1);
      stream = 8'b00001011;
      hits = '0;
      for (int i = 0; i < 4; i++) begin
         send(stream[3-i]); hits[2*i] = m_obs;
         idle();            hits[2*i+1] = m_obs;
      end
      check("gap_hits", hits, 8'b01000000);

      // Rejected load, then load colliding with a valid bit
      drive(0, 0, 0, 0, 1);
      idle();
      load(8'b1011, 0, 1);
      idle();
      check("rej_err", cfg_err, 1);
      check("rej_armed", armed, 0);
      idle();
      check("rej_err_end", cfg_err, 0);
      cfg_pattern = 8'b1011; cfg_len = 4; cfg_overlap = 1;
      drive(1, 1, 1, 0, 0);
      check("coll_match", m_obs, 0);
      hits = '0;
      send(0); hits[0] = m_obs;
      send(1); hits[1] = m_obs;
      send(1); hits[2] = m_obs;
      check("coll_hits", hits, 0);
      check("coll_armed", armed, 1);

      // Saturation of the 2-bit counter and clear-vs-match priority
      load(8'b1, 1, 0);
      drive(0, 0, 0, 1, 0);
      send(1);
      for (int i = 0; i < 4; i++) begin send(1); sat_obs[i] = match_cnt_s; end
      idle(); sat_obs[4] = match_cnt_s;
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) check($sformatf("sat_cnt%0d", i), sat_obs[i], sat_exp[i]);
      drive(1, 1, 0, 1, 0);
      check("clr_match", m_obs, 1);
      idle();
      check("clr_cnt_s", match_cnt_s, 0);
      check("clr_cnt", match_cnt, 0);

      // Reset after 3 of 4 bits discards the partial window
      load(8'b1011, 4, 1);
      send(1); send(0); send(1);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      check("rst_mid_armed", armed, 0);
      load(8'b1011, 4, 1);
      send(1);
      check("rst_mid_match", m_obs, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         logic r, ld, v, b, cl;
         r  = ($urandom % 1000) < 5;
         ld = ($urandom % 100) < 4;
         v  = ($urandom % 10) < 7;
         b  = $urandom % 2;
         cl = ($urandom % 100) < 2;
         if (ld) begin
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len = (($urandom % 8) == 0) ? LEN_W'($urandom_range(0, 15))
                                            : LEN_W'($urandom_range(1, 4));
            cfg_overlap = $urandom % 2;
         end
         drive(v, b, ld, cl, r);
      end
      repeat (3) idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
